down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
Loadable, prescaled 8-bit down-counter with a start/done handshake. It complements the existing free-running up-counters: software loads a count, pulses start, and the block decrements to zero and then flags completion. Used as a general-purpose interval timer and delay generator beside the counter blocks in the same clock domain.

Parameters:
WIDTH, 8, width of the count and load value
PRESCALE, 1, number of clk cycles per decrement; legal range 1..256

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  capture load_value into count and the reload register
load_value  input  WIDTH  value to count down from
start  input  1  begin counting; sampled on the clk edge
pause  input  1  level; while high, counting is frozen
count  output  WIDTH  current count value
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse when count reaches 0

Behaviour:
- Reset (asynchronous, highest priority) clears everything: state=IDLE, count=0, reload register=0, prescaler=0, busy=0, done=0.
- States: IDLE, RUN, HOLD. The state is encoded in 2 bits and all outputs are registered.
- Per-edge priority: load > start > pause.
- load in any state:
  - count and reload register take load_value; prescaler clears.
  - Next state is IDLE, so any running count is aborted.
  - done stays 0.
  - A start in the same cycle is ignored.
- start in IDLE:
  - count != 0: go to RUN and clear the prescaler.
  - count == 0: ignored; stay in IDLE with no done.
  - start in RUN or HOLD is ignored.
- RUN:
  - The prescaler counts 0..PRESCALE-1.
  - On the edge where the prescaler equals PRESCALE-1, count decrements by 1 and the prescaler wraps to 0.
  - With PRESCALE=1, count decrements on every edge.
- Latency: with start sampled at edge N, busy=1 after edge N and the first decrement occurs at edge N+PRESCALE.
- Terminal count:
  - On the edge where count goes from 1 to 0, done=1 for exactly that following cycle.
  - In the same edge, state goes to IDLE (busy=0), unless auto-reload is compiled in (see Optional Feature).
  - Total from start edge to done: load_value*PRESCALE cycles.
- HOLD:
  - pause=1 in RUN enters HOLD at the next edge; count and prescaler are frozen.
  - pause=0 returns to RUN at the next edge, and the prescaler resumes from its frozen value.
  - pause in IDLE has no effect.
  - pause asserted on the same edge as a scheduled decrement blocks that decrement.
- Wrap-around: count never decrements below 0; there is no underflow wrap to all-ones.
- Width rules:
  - The prescaler is sized as $clog2(PRESCALE), minimum 1 bit.
  - Arithmetic is unsigned, and count is always truncated to WIDTH.
- Reset mid-RUN: immediate return to IDLE with count=0; no done pulse.

Optional Feature:
Macro DOWNCNT_AUTORELOAD_EN.
- Defined:
  - On terminal count, done pulses and count reloads from the reload register on the same edge.
  - The state stays RUN and busy stays 1, giving a periodic done every reload*PRESCALE cycles.
  - If the reload register is 0, the block goes to IDLE instead.
  - load still aborts to IDLE.
- Undefined: the block is single-shot. It returns to IDLE at zero, and the reload register is not needed for counting.

Test Plan:
- Reset mid-count: PRESCALE=1, load 5, start, assert reset after 2 cycles -> count=0, busy=0 immediately (asynchronously), no done.
- Basic countdown: PRESCALE=1, load 5, start at edge N -> count 4,3,2,1,0 on edges N+1..N+5; done=1 only in the cycle after edge N+5; busy falls at N+5.
- Prescaled count: PRESCALE=4, load 3, start -> decrements every 4th edge; done after 12 cycles.
- Pause in RUN: PRESCALE=1, load 10, start, pause high for 3 cycles after count=7 -> count holds 7 for 3 cycles, resumes, done 13 cycles after start; also, start with count=0 -> ignored, busy=0.
- Load abort: load 8, start, load 2 while count=5 -> IDLE with count=2, no done; load+start in the same cycle -> IDLE, start ignored.
- Auto-reload (DOWNCNT_AUTORELOAD_EN defined): load 3, start -> done pulses every 3 cycles for 3 periods, busy stays 1; load 0 then start -> ignored.

Source files
------------

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable, prescaled down-counter with start/done handshake
// Ports: clk, reset (async, active-high), load/load_value capture a count,
// start begins counting, pause freezes it; count/busy/done are registered.
// Optional macro DOWNCNT_AUTORELOAD_EN: on terminal count reload and keep running.
module down_counter_timer #(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int PM = PRESCALE - 1;
  localparam logic [PW-1:0] PMAX = PW'(PM);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] psc, psc_n;
  logic [WIDTH-1:0] count_n;
  logic done_n;
`ifdef DOWNCNT_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
  always_ff @(posedge clk or posedge reset)
    if (reset) reload <= '0;
    else if (load) reload <= load_value;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      psc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      psc   <= psc_n;
      busy  <= state_n != IDLE;
      done  <= done_n;
    end
  end
  // A non-paused edge in HOLD resumes and advances the prescaler on that same edge.
  always_comb begin
    state_n = state;
    count_n = count;
    psc_n   = psc;
    done_n  = 1'b0;
    if (load) begin
      state_n = IDLE;
      count_n = load_value;
      psc_n   = '0;
    end else if (state == IDLE) begin
      if (start && count != '0) begin
        state_n = RUN;
        psc_n   = '0;
      end
    end else if (pause) begin
      state_n = HOLD;
    end else if (psc != PMAX) begin
      state_n = RUN;
      psc_n   = psc + 1'b1;
    end else begin
      state_n = RUN;
      psc_n   = '0;
      count_n = count - 1'b1;
      if (count == WIDTH'(1)) begin
        done_n = 1'b1;
`ifdef DOWNCNT_AUTORELOAD_EN
        if (reload != '0) count_n = reload;
        else state_n = IDLE;
`else
        state_n = IDLE;
`endif
      end
    end
  end
endmodule
